// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - 32-bit SPI slave receiver with framing checks; reply shifter on MISO
// built only when SPI_SLAVE_MISO_EN is defined.
module spi_slave_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             SSEL,
  input  logic             SCK,
  input  logic             DATA_IN,
  input  logic [WIDTH-1:0] tx_data,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [5:0] FULL_CNT = 6'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES:0]   ssel_q;
  logic [SYNC_STAGES:0]   sck_q;
  logic [SYNC_STAGES-1:0] din_q;
  logic [5:0]             bitcnt;
  logic [WIDTH-1:0]       shift_q;
  logic                   overrun;

  logic ssel_fall, ssel_rise, sck_rise, sck_fall, din_s;
  logic frame_start, bit_take, frame_good, frame_bad;

  // Top bit of each pin chain is the history flop; edges come from the last two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ssel_q <= '1;
      sck_q  <= '0;
      din_q  <= '0;
    end else begin
      ssel_q <= {ssel_q[SYNC_STAGES-1:0], SSEL};
      sck_q  <= {sck_q[SYNC_STAGES-1:0], SCK};
      din_q  <= {din_q[SYNC_STAGES-2:0], DATA_IN};
    end
  end

  assign ssel_fall = ssel_q[SYNC_STAGES] & ~ssel_q[SYNC_STAGES-1];
  assign ssel_rise = ~ssel_q[SYNC_STAGES] & ssel_q[SYNC_STAGES-1];
  assign sck_rise  = ~sck_q[SYNC_STAGES] & sck_q[SYNC_STAGES-1];
  assign sck_fall  = sck_q[SYNC_STAGES] & ~sck_q[SYNC_STAGES-1];
  assign din_s     = din_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (ssel_fall) state_nxt = SHIFT;
        SHIFT:   if (ssel_rise) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A bit taken in the same cycle as SSEL rising is counted before DONE is judged.
  always_comb begin
    frame_start = 1'b0;
    bit_take    = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    if (en) begin
      frame_start = (state == IDLE) && ssel_fall;
      bit_take    = (state == SHIFT) && sck_rise;
      frame_good  = (state == DONE) && (bitcnt == FULL_CNT) && !overrun;
      frame_bad   = (state == DONE) && !((bitcnt == FULL_CNT) && !overrun);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt  <= '0;
      shift_q <= '0;
      overrun <= 1'b0;
    end else if (frame_start) begin
      bitcnt  <= '0;
      shift_q <= '0;
      overrun <= 1'b0;
    end else if (bit_take) begin
      if (bitcnt < FULL_CNT) begin
        shift_q <= {shift_q[WIDTH-2:0], din_s};
        bitcnt  <= bitcnt + 6'd1;
      end else begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rx_valid  <= frame_good;
      frame_err <= frame_bad;
      if (frame_good) begin
        rx_data   <= shift_q;
        frame_cnt <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef SPI_SLAVE_MISO_EN
  logic [WIDTH-1:0] tx_shift;

  // Shifting on falling edges keeps the next bit stable across the master's sampling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= '0;
    end else if (frame_start) begin
      tx_shift <= tx_data;
    end else if (en && (state == SHIFT) && sck_fall) begin
      tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  assign MISO = (state == SHIFT) ? tx_shift[WIDTH-1] : 1'b0;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, sck_fall};
  assign MISO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx (MISO checks follow SPI_SLAVE_MISO_EN).
module tb_spi_slave_rx;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, en, SSEL, SCK, DATA_IN;
  logic [W-1:0]  tx_data;
  logic          MISO;
  logic [W-1:0]  rx_data;
  logic          rx_valid, frame_err;
  logic [CW-1:0] frame_cnt;

  spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .SSEL(SSEL), .SCK(SCK), .DATA_IN(DATA_IN),
    .tx_data(tx_data), .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int valid_seen = 0, err_seen = 0;
  int latency;
  logic [W-1:0] miso_word;
  logic [W-1:0] exp_rx;
  int exp_cnt;

  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    bit           sync_end;
    bit           exp_valid;
    bit           exp_err;
  } vec_t;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid)  valid_seen++;
      if (frame_err) err_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master model: abort_at >= 0 leaves SSEL low and returns before that bit.
  task automatic send_frame(input logic [W-1:0] word, input int nbits, input int half,
                            input int abort_at, input bit sync_end);
    SSEL = 1'b0;
    miso_word = '0;
    latency = 0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) return;
      DATA_IN = (i < W) ? word[W-1-i] : 1'($urandom);
      wait_clk(half);
      if (i < W) miso_word[W-1-i] = MISO;
      SCK = 1'b1;
      if (sync_end && i == nbits - 1) begin
        SSEL = 1'b1;
        break;
      end
      wait_clk(half);
      SCK = 1'b0;
    end
    if (!(sync_end && nbits > 0)) begin
      wait_clk(half);
      SSEL = 1'b1;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rx_valid || frame_err) begin
        latency = c;
        break;
      end
    end
    SCK = 1'b0;
    wait_clk(half + 4);
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] word, input int nbits,
                               input int half, input bit sync_end, input bit ev, input bit ee);
    int v0, e0;
    v0 = valid_seen;
    e0 = err_seen;
    send_frame(word, nbits, half, -1, sync_end);
    if (ev) begin
      exp_rx  = word;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end
    check({name, " rx_valid pulses"}, 64'(valid_seen - v0), 64'(ev));
    check({name, " frame_err pulses"}, 64'(err_seen - e0), 64'(ee));
    check({name, " rx_data"}, 64'(rx_data), 64'(exp_rx));
    check({name, " frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
    check({name, " latency"}, 64'(latency), 64'(SS + 2));
  endtask

  initial begin
    vec_t vecs[8];
    int v0, e0;
    logic [W-1:0] word;
    int nbits;
    bit good, sync_end;

    vecs[0] = '{32'hA5C3_0F81, 32, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h1234_5678, 20, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_0000, 33, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 0,  1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0001, 31, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h0F0F_0F0F, 32, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0000, 32, 1'b0, 1'b1, 1'b0};

    reset = 1'b0; en = 1'b1; SSEL = 1'b1; SCK = 1'b0; DATA_IN = 1'b0; tx_data = '0;
    exp_rx = '0;
    exp_cnt = 0;
    wait_clk(3);
    check("reset outputs", {rx_data, frame_cnt, rx_valid, frame_err, MISO}, '0);
    reset = 1'b1;
    wait_clk(3);
    check("idle outputs", {rx_data, frame_cnt, rx_valid, frame_err, MISO}, '0);

    for (int i = 0; i < 8; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].word, vecs[i].nbits, 4,
                    vecs[i].sync_end, vecs[i].exp_valid, vecs[i].exp_err);

    for (int i = 0; i < 24; i++) begin
      word     = $urandom;
      nbits    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 33) : W;
      sync_end = ($urandom_range(0, 1) == 1) && (nbits > 0);
      good     = (nbits == W);
      run_and_check($sformatf("rand%0d", i), word, nbits, $urandom_range(3, 5),
                    sync_end, good, !good);
    end

    // en dropped mid-frame: frame discarded silently, later SCK ignored until a new SSEL fall
    v0 = valid_seen;
    e0 = err_seen;
    send_frame(32'hCAFE_F00D, W, 4, 12, 1'b0);
    en = 1'b0;
    wait_clk(3);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_clk(4); SCK = 1'b1; wait_clk(4); SCK = 1'b0;
    end
    wait_clk(4);
    SSEL = 1'b1;
    wait_clk(12);
    check("en abort rx_valid pulses", 64'(valid_seen - v0), 0);
    check("en abort frame_err pulses", 64'(err_seen - e0), 0);
    check("en abort rx_data", 64'(rx_data), 64'(exp_rx));
    run_and_check("after en abort", 32'h3C3C_A5A5, W, 4, 1'b0, 1'b1, 1'b0);

    // Reset at bit 10, then a clean frame
    send_frame(32'hFFFF_FFFF, W, 4, 10, 1'b0);
    reset = 1'b0;
    wait_clk(2);
    check("mid-frame reset outputs", {rx_data, frame_cnt, rx_valid, frame_err, MISO}, '0);
    SSEL = 1'b1;
    SCK  = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    exp_rx = '0;
    exp_cnt = 0;
    v0 = valid_seen;
    e0 = err_seen;
    wait_clk(8);
    check("post reset pulses", 64'(valid_seen - v0 + err_seen - e0), 0);
    run_and_check("after reset", 32'h0000_0001, W, 4, 1'b0, 1'b1, 1'b0);

    tx_data = 32'hDEAD_BEEF;
    run_and_check("miso frame", 32'h1234_5678, W, 4, 1'b0, 1'b1, 1'b0);
`ifdef SPI_SLAVE_MISO_EN
    check("miso word", 64'(miso_word), 64'h0000_0000_DEAD_BEEF);
`else
    check("miso word", 64'(miso_word), 0);
`endif
    check("miso idle", 64'(MISO), 0);

    // Drive the counter up to its top value, then wrap it
    while (exp_cnt != (1 << CW) - 1)
      run_and_check("fill", $urandom, W, 3, 1'b0, 1'b1, 1'b0);
    run_and_check("wrap", 32'h5555_AAAA, W, 3, 1'b0, 1'b1, 1'b0);
    check("wrap frame_cnt zero", 64'(frame_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
